// File: rtl/sync_fifo_stream_reader.sv
// sync_fifo_stream_reader: FIFO read port to valid/ready stream through a 3-entry buffer; define SYNC_FIFO_READER_STATS_EN to add word_count_o
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    output logic                  fifo_read_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i
`ifdef SYNC_FIFO_READER_STATS_EN
    ,
    output logic [15:0]           word_count_o
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} occ_t;
    occ_t occ_q, occ_d;
    logic [1:0] wr_ptr, rd_ptr;
    logic inflight, capture, pop;
    logic [DATA_WIDTH-1:0] mem [3];

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue only from registered state so m_ready_i never reaches the FIFO combinationally
    assign fifo_read_o = rst_n_i && !fifo_empty_i && !flush_i && ({1'b0, occ_q} + {2'b00, inflight} < 3'd3);
    assign capture     = (FWFT ? fifo_read_o : inflight) && !flush_i;
    assign m_valid_o   = (occ_q != EMPTY);
    assign pop         = m_valid_o && m_ready_i;
    assign m_data_o    = (rd_ptr == 2'd2) ? mem[2] : (rd_ptr == 2'd1) ? mem[1] : mem[0];

    if (FWFT) begin : g_fwft
        assign inflight = 1'b0;
    end else begin : g_std
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) inflight <= 1'b0;
            else inflight <= fifo_read_o;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush_i) occ_d = EMPTY;
        else if (capture && !pop) occ_d = occ_t'(occ_q + 2'd1);
        else if (pop && !capture) occ_d = occ_t'(occ_q - 2'd1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q  <= EMPTY;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            occ_q  <= occ_d;
            wr_ptr <= flush_i ? 2'd0 : capture ? inc(wr_ptr) : wr_ptr;
            rd_ptr <= flush_i ? 2'd0 : pop ? inc(rd_ptr) : rd_ptr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) mem <= '{default: '0};
        else for (int i = 0; i < 3; i++) if (capture && wr_ptr == 2'(i)) mem[i] <= fifo_rd_data_i;
    end

`ifdef SYNC_FIFO_READER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) word_count_o <= 16'd0;
        else if (pop) word_count_o <= word_count_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// tb_sync_fifo_stream_reader: FWFT and standard-latency readers fed from one shared word source, each with its own FIFO model and scoreboard
module tb_sync_fifo_stream_reader;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ready = 1'b1;
    logic [31:0] src [1024];
    int n_src = 0, n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %0h want %0h", tag, got, want);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_d
        localparam bit FW = (k == 0);
        logic rd, valid, empty;
        logic [31:0] rdat = '0, fdata, head, data;
        logic [15:0] wc;
        int frd = 0, taken = 0, nrd = 0, pend = 0;
        logic [31:0] exp_q [$];
        assign empty = (frd == n_src);
        assign head  = src[frd[9:0]];
        assign fdata = FW ? head : rdat;
        sync_fifo_stream_reader #(.DATA_WIDTH(32), .FWFT(FW)) u_dut (
            .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .fifo_read_o(rd),
            .fifo_rd_data_i(fdata), .fifo_empty_i(empty), .m_valid_o(valid),
            .m_data_o(data), .m_ready_i(ready)
`ifdef SYNC_FIFO_READER_STATS_EN
            , .word_count_o(wc)
`endif
        );
`ifndef SYNC_FIFO_READER_STATS_EN
        assign wc = 16'd0;
`endif
        always @(posedge clk) begin
            if (rd) begin
                check($sformatf("no_underread%0d", k), empty, 1'b0);
                frd  <= frd + 1;
                rdat <= head;
                nrd  <= nrd + 1;
            end
        end
        // Words taken from the FIFO but never accepted are lost on flush/reset
        always @(negedge clk) begin
            while (taken < n_src) begin
                exp_q.push_back(src[taken[9:0]]);
                taken++;
            end
            if (rst_n && valid && ready) begin
                if (exp_q.size() != 0) check($sformatf("word%0d", k), data, exp_q.pop_front());
                else check($sformatf("extra_word%0d", k), data, 32'hDEAD_BEEF);
            end
            if (!rst_n || flush) begin
                exp_q.delete();
                for (int i = frd; i < n_src; i++) exp_q.push_back(src[i[9:0]]);
            end
            pend = exp_q.size();
        end
    end

    task automatic push(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) src[10'(n_src + i)] = base + 32'(i);
        n_src += n;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_valid"}, {g_d[1].valid, g_d[0].valid}, 2'b00);
        check({tag, "_read"}, {g_d[1].rd, g_d[0].rd}, 2'b00);
        check({tag, "_data_fwft"}, g_d[0].data, 0);
        check({tag, "_data_std"}, g_d[1].data, 0);
`ifdef SYNC_FIFO_READER_STATS_EN
        check({tag, "_count"}, {g_d[1].wc, g_d[0].wc}, 0);
`endif
    endtask

    task automatic chk_drained(input string tag);
        check({tag, "_pend_fwft"}, g_d[0].pend, 0);
        check({tag, "_pend_std"}, g_d[1].pend, 0);
    endtask

    initial begin
        logic [9:0] v0, v1;
        int r0, r1, t;
        #12;
        chk_idle("por");
        step(1);
        rst_n = 1'b1;
        step(1);
        push(8, 32'd1);
        v0 = '0;
        v1 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("first_read", {g_d[1].rd, g_d[0].rd}, 2'b11);
            v0 = {v0[8:0], g_d[0].valid};
            v1 = {v1[8:0], g_d[1].valid};
        end
        check("lat_tput_fwft", v0, 10'b0111111110);
        check("lat_tput_std", v1, 10'b0011111111);
        step(2);
        chk_drained("stream8");
`ifdef SYNC_FIFO_READER_STATS_EN
        check("count8", {g_d[1].wc, g_d[0].wc}, {16'd8, 16'd8});
`endif
        ready = 1'b0;
        push(6, 32'h100);
        r0 = g_d[0].nrd;
        r1 = g_d[1].nrd;
        step(10);
        check("bp_reads_fwft", g_d[0].nrd - r0, 3);
        check("bp_reads_std", g_d[1].nrd - r1, 3);
        check("bp_valid", {g_d[1].valid, g_d[0].valid}, 2'b11);
        check("bp_hold_fwft", g_d[0].data, 32'h100);
        check("bp_hold_std", g_d[1].data, 32'h100);
        ready = 1'b1;
        step(10);
        chk_drained("bp");
        ready = 1'b0;
        push(10, 32'h200);
        step(3);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_valid", {g_d[1].valid, g_d[0].valid}, 2'b00);
        ready = 1'b1;
        t = 0;
        while (!g_d[1].valid && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("flush_next_std", {g_d[1].valid, g_d[1].data}, {1'b1, 32'h203});
        step(12);
        chk_drained("flush_bp");
        ready = 1'b0;
        push(6, 32'h300);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        step(2);
        rst_n = 1'b1;
        ready = 1'b1;
        step(10);
        chk_drained("post_rst");
`ifdef SYNC_FIFO_READER_STATS_EN
        check("count_post_rst", {g_d[1].wc, g_d[0].wc}, {16'd4, 16'd4});
`endif
        push(10, 32'h400);
        step(3);
        flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_read", {g_d[1].rd, g_d[0].rd}, 2'b00);
        step(1);
        flush = 1'b0;
        check("flush_flow_valid", {g_d[1].valid, g_d[0].valid}, 2'b00);
        step(15);
        chk_drained("flush_flow");
`ifdef SYNC_FIFO_READER_STATS_EN
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        for (int i = 0; i < 65537; i++) begin
            push(1, 32'h10000 + 32'(i));
            step(1);
        end
        step(6);
        check("count_wrap", {g_d[1].wc, g_d[0].wc}, {16'd1, 16'd1});
        chk_drained("wrap");
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
